// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch slice.
//   fetch_state_e    : fetch FSM states (idle / request outstanding / drop response)
//   NOP_INSTR        : instruction presented while nothing is buffered (addi x0,x0,0)
//   RESET_PC_DEFAULT : default first fetch address after reset
//   word_align()     : clears the byte-offset bits of an address
package riscv_pkg;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: circular FIFO of {instruction, pc} entries.
//   i_clk, i_nrst            : clock, synchronous active-low reset
//   i_push, i_push_data/_pc  : write one entry (ignored when full and not popping)
//   i_pop                    : drop the head entry (ignored when empty)
//   i_flush                  : empty the buffer; overrides push and pop
//   o_head_data, o_head_pc   : head entry contents (undefined when empty)
//   o_count                  : number of valid entries, 0..DEPTH
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_push,
    input  logic [31:0]            i_push_data,
    input  logic [31:0]            i_push_pc,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [31:0]            o_head_data,
    output logic [31:0]            o_head_pc,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    logic [31:0]   r_data [DEPTH];
    logic [31:0]   r_pc   [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop && (r_count != '0);
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign w_push = i_push && ((r_count != FULL) || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_data[r_wr_ptr] <= i_push_data;
            r_pc[r_wr_ptr]   <= i_push_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = r_data[r_rd_ptr];
    assign o_head_pc   = r_pc[r_rd_ptr];
    assign o_count     = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential prefetch into a small buffer, with
// branch redirect and discard of a response that is in flight at redirect.
//   clk, nrst                    : clock, synchronous active-low reset
//   branch_taken, branch_target  : one-cycle redirect request and its address
//   stall                        : core does not consume the presented instruction
//   imem_req, imem_addr          : memory read request (held until imem_ack)
//   imem_ack, imem_rdata         : memory completion and read data
//   instruction, instr_pc        : head of the buffer (NOP / fetch_pc when empty)
//   instr_valid                  : buffer non-empty
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);

    localparam int unsigned   CW       = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_drop_addr;
    logic [CW-1:0] w_count;
    logic [31:0]   w_head_data;
    logic [31:0]   w_head_pc;
    logic          w_valid;
    logic          w_pop;
    logic          w_push;

    // A redirect overrides consumption and any data arriving in the same cycle.
    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid && !stall && !branch_taken;
    assign w_push  = (r_state == F_REQ) && imem_ack && !branch_taken;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= F_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        imem_addr   = r_fetch_pc;
        case (r_state)
            F_IDLE: begin
                if (branch_taken || (w_count < FULL_CNT)) begin
                    w_state_nxt = F_REQ;
                end
            end
            F_REQ: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    w_state_nxt = imem_ack ? F_REQ : F_DROP;
                end else if (imem_ack && !w_pop && (w_count == FULL_CNT - CW'(1))) begin
                    w_state_nxt = F_IDLE;
                end
            end
            F_DROP: begin
                // fetch_pc already holds the redirect target, so the abandoned
                // request's address is replayed from r_drop_addr until its ack.
                imem_req  = 1'b1;
                imem_addr = r_drop_addr;
                if (imem_ack) begin
                    w_state_nxt = F_REQ;
                end
            end
            default: begin
                w_state_nxt = F_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_fetch_pc  <= word_align(RESET_PC);
            r_drop_addr <= word_align(RESET_PC);
        end else begin
            if (branch_taken) begin
                r_fetch_pc <= word_align(branch_target);
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if ((r_state == F_REQ) && branch_taken && !imem_ack) begin
                r_drop_addr <= r_fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_push      (w_push),
        .i_push_data (imem_rdata),
        .i_push_pc   (r_fetch_pc),
        .i_pop       (w_pop),
        .i_flush     (branch_taken),
        .o_head_data (w_head_data),
        .o_head_pc   (w_head_pc),
        .o_count     (w_count)
    );

    assign instr_valid = w_valid;
    assign instruction = w_valid ? w_head_data : NOP_INSTR;
    assign instr_pc    = w_valid ? w_head_pc   : r_fetch_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// redirect sequences, randomized run against a stream-level reference model,
// and a wrap-around run on a second instance.
module tb_fetch_unit;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst, branch_taken, stall, imem_ack;
    logic [31:0] branch_target, imem_rdata;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instruction, instr_pc;

    logic        w_nrst, w_branch, w_stall, w_ack;
    logic [31:0] w_target, w_rdata;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_ipc;

    fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .nrst(nrst), .branch_taken(branch_taken), .branch_target(branch_target),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instruction(instruction), .instr_pc(instr_pc),
        .instr_valid(instr_valid)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_wrap (
        .clk(clk), .nrst(w_nrst), .branch_taken(w_branch), .branch_target(w_target),
        .stall(w_stall), .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
        .imem_rdata(w_rdata), .instruction(w_instr), .instr_pc(w_ipc),
        .instr_valid(w_valid)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; memory returns addr ^ K.
    task automatic drive(input logic br, input logic [31:0] tgt, input logic st, input logic ack);
        @(negedge clk);
        branch_taken  = br;
        branch_target = tgt;
        stall         = st;
        imem_ack      = ack;
        imem_rdata    = imem_addr ^ K;
    endtask

    typedef struct {
        logic        nrst;
        logic        br;
        logic [31:0] tgt;
        logic        stall;
        logic        ack;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ipc;
        logic [31:0] ins;
    } vec_t;

    vec_t        tbl [23];
    logic [31:0] wexp [3];

    logic [31:0] exp_pc, held, tgt;
    bit          busy, after_br, br, st, ack;
    int unsigned wait_left;
    int          consumed, got;

    initial begin
        // nrst br tgt stall ack | req addr valid instr_pc instruction
        tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   NOP};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   NOP};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   NOP};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h4,   1'b1, 32'h0,   K};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h8,   1'b1, 32'h4,   K ^ 32'h4};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'hC,   1'b1, 32'h8,   K ^ 32'h8};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h10,  1'b1, 32'h8,   K ^ 32'h8};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h10,  1'b1, 32'h8,   K ^ 32'h8};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h10,  1'b1, 32'h8,   K ^ 32'h8};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h10,  1'b1, 32'hC,   K ^ 32'hC};
        tbl[10] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h10,  1'b0, 32'h10,  NOP};
        tbl[11] = '{1'b1, 1'b1, 32'h203, 1'b0, 1'b1, 1'b1, 32'h10,  1'b0, 32'h10,  NOP};
        tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h200, NOP};
        tbl[13] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h200, NOP};
        tbl[14] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h204, 1'b1, 32'h200, K ^ 32'h200};
        tbl[15] = '{1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h204, 1'b1, 32'h200, K ^ 32'h200};
        tbl[16] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h204, 1'b0, 32'h100, NOP};
        tbl[17] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h204, 1'b0, 32'h100, NOP};
        tbl[18] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h100, NOP};
        tbl[19] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h104, 1'b1, 32'h100, K ^ 32'h100};
        tbl[20] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 32'h104, NOP};
        tbl[21] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   NOP};
        tbl[22] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 32'h0,   NOP};
        wexp[0] = 32'hFFFF_FFF8;
        wexp[1] = 32'hFFFF_FFFC;
        wexp[2] = 32'h0000_0000;

        nrst = 1'b0; branch_taken = 1'b0; branch_target = '0; stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        w_nrst = 1'b0; w_branch = 1'b0; w_target = '0; w_stall = 1'b0;
        w_ack = 1'b0; w_rdata = '0;
        repeat (2) @(posedge clk);

        // Directed vector table
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            nrst = tbl[i].nrst;
            branch_taken = tbl[i].br; branch_target = tbl[i].tgt;
            stall = tbl[i].stall; imem_ack = tbl[i].ack;
            imem_rdata = imem_addr ^ K;
            chk($sformatf("v%0d_req", i),   {31'd0, imem_req},    {31'd0, tbl[i].req});
            chk($sformatf("v%0d_addr", i),  imem_addr,            tbl[i].addr);
            chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].valid});
            chk($sformatf("v%0d_pc", i),    instr_pc,             tbl[i].ipc);
            chk($sformatf("v%0d_instr", i), instruction,          tbl[i].ins);
        end

        // Second redirect while a discarded response is still outstanding
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        chk("drop_start_addr", imem_addr, 32'h0);
        drive(1'b1, 32'h401, 1'b0, 1'b0);
        chk("drop_hold_req", {31'd0, imem_req}, 32'd1);
        chk("drop_hold_addr", imem_addr, 32'h0);
        chk("drop_pc1", instr_pc, 32'h300);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("drop_hold_addr2", imem_addr, 32'h0);
        chk("drop_pc2", instr_pc, 32'h400);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("drop_target_addr", imem_addr, 32'h400);
        chk("drop_target_valid", {31'd0, instr_valid}, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drop_first_valid", {31'd0, instr_valid}, 32'd1);
        chk("drop_first_pc", instr_pc, 32'h400);
        chk("drop_first_instr", instruction, K ^ 32'h400);

        // Redirect coincident with ack, zero-wait memory: valid two cycles later
        drive(1'b1, 32'h800, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("lat_valid0", {31'd0, instr_valid}, 32'd0);
        chk("lat_addr", imem_addr, 32'h800);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("lat_valid1", {31'd0, instr_valid}, 32'd1);
        chk("lat_pc", instr_pc, 32'h800);

        // Randomized run against the stream-level model
        @(negedge clk);
        nrst = 1'b0; branch_taken = 1'b0; stall = 1'b0; imem_ack = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        exp_pc = 32'h0; busy = 0; after_br = 0; consumed = 0; wait_left = 0; held = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (busy) begin
                chk("rnd_req_held", {31'd0, imem_req}, 32'd1);
                chk("rnd_addr_held", imem_addr, held);
            end else if (imem_req) begin
                busy = 1;
                held = imem_addr;
                wait_left = $urandom_range(0, 3);
                chk("rnd_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            end
            ack = 0;
            if (busy) begin
                if (wait_left == 0) ack = 1;
                else wait_left--;
            end
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 15) == 0);
            tgt = $urandom & 32'h0000_0FFF;
            imem_ack = ack;
            imem_rdata = ack ? (held ^ K) : $urandom;
            stall = st;
            branch_taken = br;
            branch_target = tgt;
            if (after_br) chk("rnd_flush_valid", {31'd0, instr_valid}, 32'd0);
            after_br = 0;
            if (!instr_valid) chk("rnd_empty_nop", instruction, NOP);
            if (br) begin
                exp_pc = tgt & 32'hFFFF_FFFC;
                after_br = 1;
            end else if (instr_valid && !st) begin
                chk("rnd_pc", instr_pc, exp_pc);
                chk("rnd_instr", instruction, exp_pc ^ K);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (ack) busy = 0;
        end
        chk("rnd_progress", {31'd0, consumed >= 200}, 32'd1);
        @(negedge clk);
        branch_taken = 1'b0; imem_ack = 1'b0; stall = 1'b0;

        // Address wrap on a second instance, zero-wait memory, no stall
        @(negedge clk);
        w_nrst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        w_nrst = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            w_ack = w_req;
            w_rdata = w_addr ^ K;
            if (w_valid && got < 3) begin
                chk($sformatf("wrap_pc%0d", got), w_ipc, wexp[got]);
                chk($sformatf("wrap_instr%0d", got), w_instr, wexp[got] ^ K);
                got++;
            end
        end
        chk("wrap_count", got, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, giving the number of prefetch buffer entries (power of two, 2..8).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port nrst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port branch_taken, input, 1 bit: redirect request from the core, one-cycle pulse.
REQ-006 SHALL have port branch_target, input, 32 bits: redirect address, valid with branch_taken.
REQ-007 SHALL have port stall, input, 1 bit: when high, the core does not consume the presented instruction.
REQ-008 SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-009 SHALL have port imem_addr, output, 32 bits: word address of the request.
REQ-010 SHALL have port imem_ack, input, 1 bit: memory completes the request this cycle.
REQ-011 SHALL have port imem_rdata, input, 32 bits: read data, valid with imem_ack.
REQ-012 SHALL have port instruction, output, 32 bits: instruction presented to the core.
REQ-013 SHALL have port instr_pc, output, 32 bits: address of the presented instruction.
REQ-014 SHALL have port instr_valid, output, 1 bit: instruction/instr_pc are valid.

Function
REQ-015 SHALL implement FSM states F_IDLE (no request, buffer full), F_REQ (request outstanding) and F_DROP (outstanding response to be discarded).
REQ-016 SHALL go from F_IDLE to F_REQ when buffer count < BUF_DEPTH, and go back to F_IDLE after an ack that fills the buffer.
REQ-017 SHALL drive imem_req high in F_REQ and F_DROP; imem_addr SHALL equal fetch_pc, with bits [1:0] = 2'b00.
REQ-018 SHALL hold imem_req and imem_addr stable from assertion until the ack cycle; a request is never withdrawn before ack.
REQ-019 SHALL push {imem_rdata, imem_addr} into the buffer on imem_ack in F_REQ, then fetch_pc += 4.
REQ-020 SHALL issue back-to-back requests: after an ack with room left, imem_req stays high the next cycle with the new address.
REQ-021 SHALL drive instr_valid = buffer non-empty, with instruction/instr_pc taken from the head entry.
REQ-022 SHALL pop the head at a rising edge when instr_valid=1 and stall=0; a pop and a push in the same cycle leave the count unchanged.
REQ-023 SHALL drive instruction=32'h0000_0013 (NOP) and instr_pc=fetch_pc while the buffer is empty.
REQ-024 SHALL, on branch_taken, flush the buffer, set fetch_pc = {branch_target[31:2], 2'b00}, and set instr_valid=0 on the next cycle.
REQ-025 SHALL, on branch_taken in F_REQ without ack the same cycle, go to F_DROP; the next ack is discarded, then the FSM goes to F_REQ at the target.
REQ-026 SHALL, on branch_taken coincident with imem_ack, discard that data and request the target the next cycle (no F_DROP).
REQ-027 SHALL, on branch_taken while in F_DROP, update fetch_pc to the new target and stay in F_DROP.
REQ-028 SHALL give branch_taken priority over pop, push and stall in the same cycle.
REQ-029 SHALL wrap fetch_pc modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-030 SHALL have a latency of 2 cycles from redirect to instr_valid with a zero-wait memory (ack in the first request cycle).

Reset
REQ-031 SHALL, while nrst=0 at a rising edge, clear FSM to F_IDLE, fetch_pc to RESET_PC, buffer count to 0, imem_req to 0 and instr_valid to 0; instruction shows NOP.
REQ-032 SHALL abandon an outstanding request on reset mid-operation; an ack arriving while nrst=0 or in the cycle after release is ignored.
REQ-033 SHALL assert the first imem_req (addr=RESET_PC) in the cycle after nrst rises.

Structure
REQ-034 SHALL place the fetch FSM state typedef, the NOP constant and the RESET_PC default in the shared package riscv_pkg.
REQ-035 SHALL implement the prefetch buffer as sub-module fetch_fifo (data+pc entries, push/pop/flush, count output).

Verification
REQ-036 SHALL cover zero-wait streaming: after reset, ack every cycle with rdata=addr^32'hA5A5_0000 -> instr_pc = 0, 4, 8, ... each cycle with stall=0.
REQ-037 SHALL cover stall backpressure: hold stall=1 for 5 cycles -> at most 2 requests complete, imem_req drops, count=2, and fetching resumes on release with no skipped or duplicated pc.
REQ-038 SHALL cover redirect with 3-cycle memory latency: branch_taken with target 32'h100 mid-request -> the old response is discarded and the next valid instruction has instr_pc = 32'h100.
REQ-039 SHALL cover branch coincident with ack: target 32'h203 -> the acked data is dropped and the next imem_addr = 32'h200.
REQ-040 SHALL cover wrap: RESET_PC = 32'hFFFF_FFF8 -> instr_pc = FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-041 SHALL cover mid-request reset: nrst low during F_REQ -> imem_req=0 and instr_valid=0 next cycle, and the first request after release is at RESET_PC.
